// File: rtl/pulse_gen_pkg.sv
// Shared types and sizing helpers for the pulse_gen event-to-waveform generator.
package pulse_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } pg_state_t;

  // Width of a down-counter that must hold values up to max(h, l).
  function automatic int unsigned cnt_width(input int unsigned h, input int unsigned l);
    int unsigned m;
    m = (h > l) ? h : l;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up/down counter: simultaneous inc/dec nets to zero, an inc while
// full is dropped and reported for exactly one cycle on sat_drop.
module sat_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         sat_drop
);

  logic [W-1:0] r_count;
  logic         r_drop;
  logic         w_full;
  logic         w_empty;
  logic         w_drop;

  always_comb begin
    w_full  = &r_count;
    w_empty = (r_count == '0);
    w_drop  = inc & ~dec & w_full;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
      r_drop  <= 1'b0;
    end else begin
      r_drop <= w_drop;
      if (inc && !dec && !w_full) begin
        r_count <= r_count + W'(1);
      end else if (dec && !inc && !w_empty) begin
        r_count <= r_count - W'(1);
      end
    end
  end

  assign count    = r_count;
  assign sat_drop = r_drop;

endmodule

// File: rtl/pulse_gen.sv
// Turns single-cycle triggers into HIGH_CYCLES-wide pulses separated by at least
// LOW_CYCLES low clocks; triggers arriving mid-pulse are queued in sat_counter.
module pulse_gen
  import pulse_gen_pkg::*;
#(
  parameter int unsigned HIGH_CYCLES = 4,
  parameter int unsigned LOW_CYCLES  = 4,
  parameter int unsigned PEND_W      = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              trigger,
  output logic              pulse_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  localparam int unsigned CntW = cnt_width(HIGH_CYCLES, LOW_CYCLES);
  localparam logic [CntW-1:0] HighLoad = CntW'(HIGH_CYCLES - 1);
  localparam logic [CntW-1:0] LowLoad  = CntW'(LOW_CYCLES - 1);

  pg_state_t       r_state;
  logic [CntW-1:0] r_cnt;
  logic            r_pulse;
  logic            r_busy;

  logic w_cnt_zero;
  logic w_pend_nz;
  logic w_gap_end;
  logic w_direct;
  logic w_inc;
  logic w_dec;

  always_comb begin
    w_cnt_zero = (r_cnt == '0);
    w_pend_nz  = (pending != '0);
    w_gap_end  = (r_state == LOW) && w_cnt_zero;
    // A trigger that starts the next pulse itself never enters the queue.
    w_direct   = trigger && ((r_state == IDLE) || (w_gap_end && !w_pend_nz));
    w_dec      = w_pend_nz && (w_gap_end || ((r_state == IDLE) && !trigger));
    w_inc      = trigger && !w_direct;
  end

  sat_counter #(
    .W(PEND_W)
  ) u_pend (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (w_inc),
    .dec     (w_dec),
    .count   (pending),
    .sat_drop(overflow)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_pulse <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (trigger || w_pend_nz) begin
            r_state <= HIGH;
            r_cnt   <= HighLoad;
            r_pulse <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        HIGH: begin
          if (!w_cnt_zero) begin
            r_cnt <= r_cnt - CntW'(1);
          end else begin
            r_state <= LOW;
            r_cnt   <= LowLoad;
            r_pulse <= 1'b0;
          end
        end
        LOW: begin
          if (!w_cnt_zero) begin
            r_cnt <= r_cnt - CntW'(1);
          end else if (w_pend_nz || trigger) begin
            r_state <= HIGH;
            r_cnt   <= HighLoad;
            r_pulse <= 1'b1;
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
          r_pulse <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign pulse_out = r_pulse;
  assign busy      = r_busy;

endmodule

// File: tb/tb_pulse_gen.sv
// Drives two pulse_gen instances (3/2/2 and 1/1/2) with directed and random triggers,
// checking every cycle against a pulse-window reference model.
module tb_pulse_gen;

  logic       clock;
  logic       reset_n;
  logic       trig_a, trig_b;
  logic       pulse_a, busy_a, ovf_a;
  logic       pulse_b, busy_b, ovf_b;
  logic [1:0] pend_a, pend_b;

  int n_vec;
  int n_err;

  // Model: position within the current HIGH+LOW window (-1 when idle).
  int hc[2];
  int lc[2];
  int pos[2];
  int pend[2];
  int ovf[2];
  localparam int PendMax = 3;

  pulse_gen #(.HIGH_CYCLES(3), .LOW_CYCLES(2), .PEND_W(2)) dut_a (
    .clock    (clock),
    .reset_n  (reset_n),
    .trigger  (trig_a),
    .pulse_out(pulse_a),
    .busy     (busy_a),
    .pending  (pend_a),
    .overflow (ovf_a)
  );

  pulse_gen #(.HIGH_CYCLES(1), .LOW_CYCLES(1), .PEND_W(2)) dut_b (
    .clock    (clock),
    .reset_n  (reset_n),
    .trigger  (trig_b),
    .pulse_out(pulse_b),
    .busy     (busy_b),
    .pending  (pend_b),
    .overflow (ovf_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      pos[d]  = -1;
      pend[d] = 0;
      ovf[d]  = 0;
    end
  endtask

  task automatic queue_trig(input int d);
    if (pend[d] == PendMax) ovf[d] = 1;
    else pend[d]++;
  endtask

  task automatic model_edge(input int d, input bit trg);
    int win;
    win    = hc[d] + lc[d];
    ovf[d] = 0;
    if (pos[d] < 0) begin
      if (trg) pos[d] = 0;
    end else if (pos[d] < win - 1) begin
      pos[d]++;
      if (trg) queue_trig(d);
    end else begin
      if (pend[d] > 0) begin
        pos[d] = 0;
        pend[d]--;
        if (trg) pend[d]++;
      end else if (trg) begin
        pos[d] = 0;
      end else begin
        pos[d] = -1;
      end
    end
  endtask

  task automatic check_all(input string where);
    for (int d = 0; d < 2; d++) begin
      logic       p, b, o;
      logic [1:0] q;
      p = (d == 0) ? pulse_a : pulse_b;
      b = (d == 0) ? busy_a  : busy_b;
      o = (d == 0) ? ovf_a   : ovf_b;
      q = (d == 0) ? pend_a  : pend_b;
      chk($sformatf("%s dut%0d pulse_out", where, d), 32'(p), 32'((pos[d] >= 0) && (pos[d] < hc[d])));
      chk($sformatf("%s dut%0d busy", where, d), 32'(b), 32'(pos[d] >= 0));
      chk($sformatf("%s dut%0d pending", where, d), 32'(q), 32'(pend[d]));
      chk($sformatf("%s dut%0d overflow", where, d), 32'(o), 32'(ovf[d]));
    end
  endtask

  task automatic step(input bit ta, input bit tb, input string where);
    trig_a = ta;
    trig_b = tb;
    @(posedge clock);
    model_edge(0, ta);
    model_edge(1, tb);
    #1;
    check_all(where);
  endtask

  task automatic idle(input int n, input string where);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, where);
  endtask

  // Assert reset away from any edge and check outputs clear without a clock.
  task automatic async_reset(input string where);
    trig_a  = 1'b0;
    trig_b  = 1'b0;
    #1;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all(where);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    hc[0]   = 3; lc[0] = 2;
    hc[1]   = 1; lc[1] = 1;
    reset_n = 1'b0;
    trig_a  = 1'b0;
    trig_b  = 1'b0;
    model_reset();
    #2;
    check_all("reset");
    @(negedge clock);
    reset_n = 1'b1;

    idle(10, "pre");
    step(1'b1, 1'b1, "single");
    idle(8, "single");

    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, "burst");
    idle(20, "burst");

    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, "ovf");
    idle(25, "ovf");

    step(1'b1, 1'b0, "boundary");
    idle(4, "boundary");
    step(1'b1, 1'b0, "boundary");
    idle(10, "boundary");

    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, "midrst");
    async_reset("midrst");
    step(1'b1, 1'b1, "postrst");
    idle(8, "postrst");

    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, "held");
    idle(12, "held");

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 0), "rand");
      if (i == 200) async_reset("randrst");
    end
    idle(15, "tail");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
